// File: rtl/l2_interco_pkg.sv
// Shared L2 interconnect types: latency bound and the response-stage record.
package l2_interco_pkg;

  localparam int MEM_LAT_MAX  = 4;
  // Widest requester ID a response stage can carry; narrower IDs are zero-extended.
  localparam int ID_WIDTH_MAX = 16;

  typedef struct packed {
    logic                    valid;
    logic [ID_WIDTH_MAX-1:0] id;
    logic                    is_load;
  } resp_stage_t;

endpackage

// File: rtl/l2_resp_delay_line.sv
// Fixed-depth valid/payload delay line; reset flushes every stage.
module l2_resp_delay_line #(
  parameter int DEPTH = 1,
  parameter int PW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [PW-1:0] in_pay,
  output logic          out_vld,
  output logic [PW-1:0] out_pay
);

  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1][PW-1:0] pay_pipe;

  // Shift valid and payload one stage per cycle; reset drops in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      pay_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      pay_pipe[1] <= in_pay;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pay_pipe[i] <= pay_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH];
  assign out_pay = pay_pipe[DEPTH];

endmodule

// File: rtl/l2_bank_adapter.sv
// L2 bank adapter: crossbar slave port to single-port SRAM, no backpressure.
module l2_bank_adapter
  import l2_interco_pkg::*;
#(
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int TAG_WIDTH      = DATA_WIDTH/8,
  parameter int ID_WIDTH       = 9,
  parameter int MEM_LAT        = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [TAG_WIDTH-1:0]      data_wtag_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_r_valid_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]      data_r_rtag_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TAG_WIDTH-1:0]      mem_wtag_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic [TAG_WIDTH-1:0]      mem_rtag_i,
  input  logic                      cnt_clear_i,
  output logic [CNT_WIDTH-1:0]      cnt_rd_o,
  output logic [CNT_WIDTH-1:0]      cnt_wr_o,
  output logic                      err_id_o
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("l2_bank_adapter: MEM_LAT must be in 1..%0d", MEM_LAT_MAX);
  end
  if (ID_WIDTH > ID_WIDTH_MAX) begin : g_bad_id
    $error("l2_bank_adapter: ID_WIDTH exceeds %0d", ID_WIDTH_MAX);
  end

  // SRAM request path is pure wiring; idle cycles force a harmless read with no bytes.
  assign mem_csn_o   = ~data_req_i;
  assign mem_wen_o   = data_req_i ? data_wen_i : 1'b1;
  assign mem_be_o    = data_req_i ? data_be_i : '0;
  assign mem_add_o   = data_add_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_wtag_o  = data_wtag_i;

  resp_stage_t        req_stage, rsp_stage;
  logic               rsp_vld;
  logic [ID_WIDTH_MAX:0] rsp_pay;
  logic               unused_rsp;

  // Build the stage record; idle cycles enter the line as all-zero so outputs idle at 0.
  always_comb begin
    req_stage = '0;
    if (data_req_i) begin
      req_stage.valid              = 1'b1;
      req_stage.id[ID_WIDTH-1:0]   = data_ID_i;
      req_stage.is_load            = data_wen_i;
    end
  end

  l2_resp_delay_line #(
    .DEPTH (MEM_LAT),
    .PW    (ID_WIDTH_MAX + 1)
  ) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (req_stage.valid),
    .in_pay  ({req_stage.id, req_stage.is_load}),
    .out_vld (rsp_vld),
    .out_pay (rsp_pay)
  );

  assign rsp_stage  = resp_stage_t'({rsp_vld, rsp_pay});
  assign unused_rsp = ^rsp_stage.id;

  assign data_r_valid_o = rsp_stage.valid;
  assign data_r_ID_o    = rsp_stage.valid ? rsp_stage.id[ID_WIDTH-1:0] : '0;
  assign data_r_rdata_o = (rsp_stage.valid && rsp_stage.is_load) ? mem_rdata_i : '0;
  assign data_r_rtag_o  = (rsp_stage.valid && rsp_stage.is_load) ? mem_rtag_i : '0;

  // Saturating load/store statistics and sticky malformed-ID flag; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rd_o <= '0;
      cnt_wr_o <= '0;
      err_id_o <= 1'b0;
    end else if (cnt_clear_i) begin
      cnt_rd_o <= '0;
      cnt_wr_o <= '0;
      err_id_o <= 1'b0;
    end else if (data_req_i) begin
      if (data_wen_i && !(&cnt_rd_o))  cnt_rd_o <= cnt_rd_o + 1'b1;
      if (!data_wen_i && !(&cnt_wr_o)) cnt_wr_o <= cnt_wr_o + 1'b1;
      if (!$onehot(data_ID_i))         err_id_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_bank_adapter.sv
// Bench: three adapter builds (latency 1/3/4) sharing one stimulus stream,
// checked every cycle against a cycle-indexed reference of the response contract.
module tb_l2_bank_adapter;

  localparam int AW = 12, DW = 64, BW = 8, TW = 8, IW = 9, ND = 3;

  function automatic int lat_of(input int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] cmax_of(input int d);
    return (d == 1) ? 32'hFFFF_FFFF : 32'd15;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req = 0, wen = 0, clr = 0;
  logic [AW-1:0] add = 0;
  logic [DW-1:0] wdata = 0;
  logic [TW-1:0] wtag = 0;
  logic [BW-1:0] be = 0;
  logic [IW-1:0] id = 0;

  logic          rv   [ND];
  logic [DW-1:0] rdat [ND];
  logic [TW-1:0] rtag [ND];
  logic [IW-1:0] rid  [ND];
  logic          csn  [ND];
  logic          mwen [ND];
  logic [AW-1:0] madd [ND];
  logic [DW-1:0] mwd  [ND];
  logic [TW-1:0] mwt  [ND];
  logic [BW-1:0] mbe  [ND];
  logic [DW-1:0] srd  [ND];
  logic [TW-1:0] srt  [ND];
  logic          err  [ND];
  logic [31:0]   crd  [ND];
  logic [31:0]   cwr  [ND];
  logic [3:0]    crd0, cwr0, crd2, cwr2;

  assign crd[0] = {28'd0, crd0};
  assign cwr[0] = {28'd0, cwr0};
  assign crd[2] = {28'd0, crd2};
  assign cwr[2] = {28'd0, cwr2};

  l2_bank_adapter #(.MEM_LAT(1), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
    .data_wdata_i(wdata), .data_wtag_i(wtag), .data_be_i(be), .data_ID_i(id),
    .data_r_valid_o(rv[0]), .data_r_rdata_o(rdat[0]), .data_r_rtag_o(rtag[0]), .data_r_ID_o(rid[0]),
    .mem_csn_o(csn[0]), .mem_wen_o(mwen[0]), .mem_add_o(madd[0]), .mem_wdata_o(mwd[0]),
    .mem_wtag_o(mwt[0]), .mem_be_o(mbe[0]), .mem_rdata_i(srd[0]), .mem_rtag_i(srt[0]),
    .cnt_clear_i(clr), .cnt_rd_o(crd0), .cnt_wr_o(cwr0), .err_id_o(err[0]));

  l2_bank_adapter #(.MEM_LAT(3), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
    .data_wdata_i(wdata), .data_wtag_i(wtag), .data_be_i(be), .data_ID_i(id),
    .data_r_valid_o(rv[1]), .data_r_rdata_o(rdat[1]), .data_r_rtag_o(rtag[1]), .data_r_ID_o(rid[1]),
    .mem_csn_o(csn[1]), .mem_wen_o(mwen[1]), .mem_add_o(madd[1]), .mem_wdata_o(mwd[1]),
    .mem_wtag_o(mwt[1]), .mem_be_o(mbe[1]), .mem_rdata_i(srd[1]), .mem_rtag_i(srt[1]),
    .cnt_clear_i(clr), .cnt_rd_o(crd[1]), .cnt_wr_o(cwr[1]), .err_id_o(err[1]));

  l2_bank_adapter #(.MEM_LAT(4), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
    .data_wdata_i(wdata), .data_wtag_i(wtag), .data_be_i(be), .data_ID_i(id),
    .data_r_valid_o(rv[2]), .data_r_rdata_o(rdat[2]), .data_r_rtag_o(rtag[2]), .data_r_ID_o(rid[2]),
    .mem_csn_o(csn[2]), .mem_wen_o(mwen[2]), .mem_add_o(madd[2]), .mem_wdata_o(mwd[2]),
    .mem_wtag_o(mwt[2]), .mem_be_o(mbe[2]), .mem_rdata_i(srd[2]), .mem_rtag_i(srt[2]),
    .cnt_clear_i(clr), .cnt_rd_o(crd2), .cnt_wr_o(cwr2), .err_id_o(err[2]));

  // SRAM fixture: byte-masked writes from dut0's port, read data delayed 1..4 cycles.
  logic [DW-1:0] sram_d [0:63];
  logic [TW-1:0] sram_t [0:63];
  logic [DW-1:0] rdp [4];
  logic [TW-1:0] rtp [4];

  always @(posedge clk) begin
    if (!csn[0] && !mwen[0])
      for (int b = 0; b < BW; b++)
        if (mbe[0][b]) begin
          sram_d[madd[0][5:0]][b*8 +: 8] <= mwd[0][b*8 +: 8];
          sram_t[madd[0][5:0]][b]        <= mwt[0][b];
        end
    rdp[0] <= sram_d[madd[0][5:0]];
    rtp[0] <= sram_t[madd[0][5:0]];
    for (int i = 1; i < 4; i++) begin
      rdp[i] <= rdp[i-1];
      rtp[i] <= rtp[i-1];
    end
  end

  assign srd[0] = rdp[0]; assign srt[0] = rtp[0];
  assign srd[1] = rdp[2]; assign srt[1] = rtp[2];
  assign srd[2] = rdp[3]; assign srt[2] = rtp[3];

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected response per (dut, cycle mod 16), memory image, counters, flag.
  logic          exp_v  [ND][16];
  logic [IW-1:0] exp_id [ND][16];
  logic [DW-1:0] exp_d  [ND][16];
  logic [TW-1:0] exp_t  [ND][16];
  logic [DW-1:0] ref_d  [0:63];
  logic [TW-1:0] ref_t  [0:63];
  logic [31:0]   m_crd  [ND];
  logic [31:0]   m_cwr  [ND];
  logic          m_err  [ND];

  initial begin
    int s, ns;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        s = cyc % 16;
        if (!rst_n) begin
          m_crd[d] = 0; m_cwr[d] = 0; m_err[d] = 0;
          for (int k = 0; k < 16; k++) begin
            exp_v[d][k] = 0; exp_id[d][k] = 0; exp_d[d][k] = 0; exp_t[d][k] = 0;
          end
        end
        chk($sformatf("d%0d_valid c%0d", d, cyc), rv[d], exp_v[d][s]);
        chk($sformatf("d%0d_rid c%0d", d, cyc), rid[d], exp_id[d][s]);
        chk($sformatf("d%0d_rdata c%0d", d, cyc), rdat[d], exp_d[d][s]);
        chk($sformatf("d%0d_rtag c%0d", d, cyc), rtag[d], exp_t[d][s]);
        chk($sformatf("d%0d_cnt_rd c%0d", d, cyc), crd[d], m_crd[d]);
        chk($sformatf("d%0d_cnt_wr c%0d", d, cyc), cwr[d], m_cwr[d]);
        chk($sformatf("d%0d_err c%0d", d, cyc), err[d], m_err[d]);
        chk($sformatf("d%0d_csn c%0d", d, cyc), csn[d], !req);
        chk($sformatf("d%0d_mwen c%0d", d, cyc), mwen[d], req ? wen : 1'b1);
        chk($sformatf("d%0d_mbe c%0d", d, cyc), mbe[d], req ? be : '0);
        chk($sformatf("d%0d_madd c%0d", d, cyc), madd[d], add);
        chk($sformatf("d%0d_mwdata c%0d", d, cyc), mwd[d], wdata);
        chk($sformatf("d%0d_mwtag c%0d", d, cyc), mwt[d], wtag);
        exp_v[d][s] = 0; exp_id[d][s] = 0; exp_d[d][s] = 0; exp_t[d][s] = 0;
        if (rst_n) begin
          if (req) begin
            ns = (cyc + lat_of(d)) % 16;
            exp_v[d][ns]  = 1'b1;
            exp_id[d][ns] = id;
            exp_d[d][ns]  = wen ? ref_d[add[5:0]] : '0;
            exp_t[d][ns]  = wen ? ref_t[add[5:0]] : '0;
          end
          if (clr) begin
            m_crd[d] = 0; m_cwr[d] = 0; m_err[d] = 0;
          end else if (req) begin
            if (wen && m_crd[d] < cmax_of(d))  m_crd[d] = m_crd[d] + 1;
            if (!wen && m_cwr[d] < cmax_of(d)) m_cwr[d] = m_cwr[d] + 1;
            if ($countones(id) != 1) m_err[d] = 1'b1;
          end
        end
      end
      if (req && !wen)
        for (int b = 0; b < BW; b++)
          if (be[b]) begin
            ref_d[add[5:0]][b*8 +: 8] = wdata[b*8 +: 8];
            ref_t[add[5:0]][b]        = wtag[b];
          end
      cyc++;
    end
  end

  task automatic set_req(input logic w, input logic [AW-1:0] a, input logic [IW-1:0] i);
    req = 1'b1; wen = w; add = a; id = i;
    wdata = {$urandom, $urandom}; wtag = 8'($urandom); be = 8'($urandom);
  endtask

  task automatic set_idle();
    req = 1'b0; wen = 1'b0; id = '0; be = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // Fill the SRAM image while the adapter is still in reset (request path is combinational).
    for (int a = 0; a < 64; a++) begin
      set_req(1'b0, AW'(a), 9'h001);
      be = 8'hFF;
      if (a == 16) wdata = 64'hDEADBEEF_00C0FFEE;
      step();
    end
    set_idle();
    @(negedge clk);
    chk("reset_valid", rv[2], 1'b0);
    chk("reset_rid", rid[2], '0);
    step();
    rst_n = 1'b1;
    step(); step();

    // Single load at latency 1.
    set_req(1'b1, 12'h010, 9'h004);
    step();
    set_idle();
    @(negedge clk);
    chk("lat1_valid", rv[0], 1'b1);
    chk("lat1_rdata", rdat[0], 64'hDEADBEEF_00C0FFEE);
    chk("lat1_rid", rid[0], 9'h004);
    step(); step(); step(); step();

    // Eight back-to-back alternating store/load requests through latency 3.
    for (int k = 0; k < 12; k++) begin
      if (k < 8) set_req(1'(k % 2), AW'(32 + k), IW'(1 << k));
      else set_idle();
      @(negedge clk);
      chk($sformatf("burst_valid k%0d", k), rv[1], (k >= 3 && k < 11));
      if (k >= 3 && k < 11) begin
        chk($sformatf("burst_rid k%0d", k), rid[1], IW'(1 << (k - 3)));
        if ((k - 3) % 2 == 0) chk($sformatf("burst_store_rdata k%0d", k), rdat[1], '0);
      end
      step();
    end

    // Store-counter saturation on the 4-bit builds, then clear against a store.
    clr = 1'b1; step(); clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_req(1'b0, AW'($urandom_range(0, 63)), IW'(1 << $urandom_range(0, 8)));
      step();
    end
    set_idle();
    @(negedge clk);
    chk("sat_cnt_wr_w4", cwr[0], 32'd15);
    chk("sat_cnt_wr_w4_lat4", cwr[2], 32'd15);
    chk("sat_cnt_wr_w32", cwr[1], 32'd20);
    step();
    set_req(1'b0, 12'h005, 9'h002);
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_idle();
    @(negedge clk);
    chk("clr_vs_store_cnt_wr", cwr[0], '0);
    chk("clr_vs_store_cnt_wr_w32", cwr[1], '0);
    step(); step(); step(); step();

    // Malformed ID: flag sets, request still served, clear drops the flag.
    set_req(1'b1, 12'h007, 9'h003);
    step();
    set_idle();
    @(negedge clk);
    chk("bad_id_err", err[0], 1'b1);
    chk("bad_id_rvalid", rv[0], 1'b1);
    chk("bad_id_rid", rid[0], 9'h003);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk);
    chk("bad_id_cleared", err[1], 1'b0);
    step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) set_req(1'($urandom), AW'($urandom_range(0, 63)), IW'($urandom));
        else set_req(1'($urandom), AW'($urandom_range(0, 63)), IW'(1 << $urandom_range(0, 8)));
      end else set_idle();
      clr = ($urandom_range(0, 31) == 0);
      step();
    end
    set_idle(); clr = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // Reset pulse with two loads in flight at latency 4.
    set_req(1'b1, 12'h010, 9'h008); step();
    set_req(1'b1, 12'h011, 9'h010); step();
    set_idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_valid k%0d", k), rv[2], 1'b0);
      if (k == 0) begin
        chk("post_reset_cnt_rd", crd[2], '0);
        chk("post_reset_cnt_wr", cwr[1], '0);
      end
      step();
    end

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
